// File: rtl/pipeline_front_regs_pkg.sv
// ============================================================================
// Module : pipeline_front_regs_pkg
// Brief  : Shared constants and next-PC source selection for the front regs.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package pipeline_front_regs_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
  localparam int          CTRL_W_DEFAULT   = 16;
  localparam int          CNT_W_DEFAULT    = 32;
  localparam logic        CTRL_BUBBLE_BIT  = 1'b0;
  localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    PC_SRC_SEQ    = 2'd0,
    PC_SRC_JUMP   = 2'd1,
    PC_SRC_BRANCH = 2'd2
  } pc_src_e;

  // A taken branch in EX is older than a jump in ID, so the jump is wrong-path.
  function automatic pc_src_e pc_src_sel(input logic branch_taken, input logic jump);
    if (branch_taken) begin
      return PC_SRC_BRANCH;
    end else if (jump) begin
      return PC_SRC_JUMP;
    end
    return PC_SRC_SEQ;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_front_regs_if.sv
// ============================================================================
// Module : pipeline_front_regs_if
// Brief  : Hazard/flush control, fetch and pipeline-register bus of the front end.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface pipeline_front_regs_if #(
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 32
);

  logic              PC_Write;
  logic              IF_ID_Write;
  logic              ctrl_Mux;
  logic              IF_Flush;
  logic              ID_Flush;
  logic              EX_BranchTaken;
  logic [31:0]       EX_BranchTarget;
  logic              ID_J;
  logic [31:0]       ID_JumpTarget;
  logic [31:0]       IF_Instruction;
  logic [CTRL_W-1:0] ID_Ctrl;

  logic [31:0]       IF_PC;
  logic [31:0]       ID_Instruction;
  logic [31:0]       ID_PC_plus4;
  logic [CTRL_W-1:0] EX_Ctrl;
  logic [31:0]       EX_PC_plus4;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;

  modport master (
    output PC_Write, IF_ID_Write, ctrl_Mux, IF_Flush, ID_Flush,
           EX_BranchTaken, EX_BranchTarget, ID_J, ID_JumpTarget,
           IF_Instruction, ID_Ctrl,
    input  IF_PC, ID_Instruction, ID_PC_plus4, EX_Ctrl, EX_PC_plus4,
           stall_count, flush_count
  );

  modport slave (
    input  PC_Write, IF_ID_Write, ctrl_Mux, IF_Flush, ID_Flush,
           EX_BranchTaken, EX_BranchTarget, ID_J, ID_JumpTarget,
           IF_Instruction, ID_Ctrl,
    output IF_PC, ID_Instruction, ID_PC_plus4, EX_Ctrl, EX_PC_plus4,
           stall_count, flush_count
  );

endinterface

`default_nettype wire

// File: rtl/pipeline_front_regs_sat_counter.sv
// ============================================================================
// Module : pipeline_front_regs_sat_counter
// Brief  : Event counter that sticks at all-ones instead of wrapping.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pipeline_front_regs_sat_counter #(
  parameter int CNT_W = 32
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             i_inc,
  output logic      [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_max = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != c_max)) begin
      r_count <= r_count + c_one;
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipeline_front_regs.sv
// ============================================================================
// Module : pipeline_front_regs
// Brief  : PC, IF/ID and ID/EX registers obeying stall/flush control, with
//          saturating stall and flush event counters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pipeline_front_regs
  import pipeline_front_regs_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int          CTRL_W   = CTRL_W_DEFAULT,
  parameter int          CNT_W    = CNT_W_DEFAULT
) (
  input wire logic                clk,
  input wire logic                reset,
  pipeline_front_regs_if.slave    bus
);

  localparam logic [CTRL_W-1:0] c_ctrl_bubble = {CTRL_W{CTRL_BUBBLE_BIT}};

  logic [31:0]       r_pc;
  logic [31:0]       r_id_instr;
  logic [31:0]       r_id_pc4;
  logic [CTRL_W-1:0] r_ex_ctrl;
  logic [31:0]       r_ex_pc4;

  pc_src_e           w_pc_src;
  logic [31:0]       w_pc_plus4;
  logic [31:0]       w_next_pc;
  logic              w_pc_en;
  logic              w_bubble;
  logic              w_stall_inc;

  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_pc_src    = pc_src_sel(bus.EX_BranchTaken, bus.ID_J);
  // A redirect flushes the stalled instruction, so it must override PC_Write.
  assign w_pc_en     = bus.PC_Write | bus.EX_BranchTaken | bus.ID_J;
  assign w_bubble    = bus.ID_Flush | ~bus.ctrl_Mux;
  assign w_stall_inc = ~bus.ctrl_Mux & ~bus.ID_Flush;

  always_comb begin
    w_next_pc = w_pc_plus4;
    case (w_pc_src)
      PC_SRC_BRANCH: w_next_pc = bus.EX_BranchTarget;
      PC_SRC_JUMP:   w_next_pc = bus.ID_JumpTarget;
      default:       w_next_pc = w_pc_plus4;
    endcase
    w_next_pc = w_next_pc & PC_ALIGN_MASK;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= PC_RESET;
    end else if (w_pc_en) begin
      r_pc <= w_next_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_id_instr <= NOP_INSTR;
      r_id_pc4   <= 32'h0;
    end else if (bus.IF_Flush) begin
      r_id_instr <= NOP_INSTR;
      r_id_pc4   <= 32'h0;
    end else if (bus.IF_ID_Write) begin
      r_id_instr <= bus.IF_Instruction;
      r_id_pc4   <= w_pc_plus4;
    end
  end

  // ID/EX never holds: a bubble only zeroes the control bundle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ex_ctrl <= c_ctrl_bubble;
      r_ex_pc4  <= 32'h0;
    end else begin
      r_ex_ctrl <= w_bubble ? c_ctrl_bubble : bus.ID_Ctrl;
      r_ex_pc4  <= r_id_pc4;
    end
  end

  pipeline_front_regs_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_stall_inc),
    .o_count (bus.stall_count)
  );

  pipeline_front_regs_sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (bus.IF_Flush),
    .o_count (bus.flush_count)
  );

  assign bus.IF_PC          = r_pc;
  assign bus.ID_Instruction = r_id_instr;
  assign bus.ID_PC_plus4    = r_id_pc4;
  assign bus.EX_Ctrl        = r_ex_ctrl;
  assign bus.EX_PC_plus4    = r_ex_pc4;

endmodule

`default_nettype wire
